// File: rtl/id_issue_queue.sv
// Decode-to-execute issue queue: DEPTH-entry FIFO of decoded bundles with tracker tags, bubble
// injection on data hazards and flush. 1-cycle min latency; In_ready drops only when full.
module id_issue_queue #(
   parameter int                   PAYLOAD_W   = 128,
   parameter int                   TRACK_W     = 8,
   parameter int                   DEPTH       = 2,
   parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
   parameter int                   CNT_W       = 16
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       In_valid,
   output logic                       In_ready,
   input  logic [PAYLOAD_W-1:0]       In_payload,
   input  logic [TRACK_W-1:0]         In_tracker,
   output logic                       Out_valid,
   input  logic                       Out_ready,
   output logic [PAYLOAD_W-1:0]       Out_payload,
   output logic [TRACK_W-1:0]         Out_tracker,
   input  logic                       Stall_data_hazard,
   input  logic                       Flush,
   output logic [$clog2(DEPTH):0]     Occupancy,
   output logic [CNT_W-1:0]           Bubble_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [PAYLOAD_W-1:0] pay_mem [DEPTH];
   logic [TRACK_W-1:0]   trk_mem [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic not_empty;
   logic enq;
   logic deq;
   logic bubble;

   always_comb begin
      not_empty = (count != '0);
      In_ready  = (count != FULL);
      Out_valid = not_empty && !Stall_data_hazard && !Flush;
      enq       = In_valid && In_ready && !Flush;
      deq       = Out_valid && Out_ready;
      bubble    = not_empty && Stall_data_hazard && !Flush;
      Occupancy = count;
   end

   always_comb begin
      Out_payload = NOP_PAYLOAD;
      Out_tracker = '0;
      if (Out_valid) begin
         Out_payload = pay_mem[rd_ptr];
         Out_tracker = trk_mem[rd_ptr];
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge Clk) begin
      if (enq) begin
         pay_mem[wr_ptr] <= In_payload;
         trk_mem[wr_ptr] <= In_tracker;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (Flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Stall on an empty queue is not a bubble; flush outranks the stall.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Bubble_count <= '0;
      end else if (bubble && !(&Bubble_count)) begin
         Bubble_count <= Bubble_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: directed scenarios plus a scoreboard/reference-model monitor.
module tb_id_issue_queue;

   localparam int DEPTH = 2;

   logic         Clk;
   logic         Reset_n;
   logic         In_valid;
   logic         In_ready;
   logic [127:0] In_payload;
   logic [7:0]   In_tracker;
   logic         Out_valid;
   logic         Out_ready;
   logic [127:0] Out_payload;
   logic [7:0]   Out_tracker;
   logic         Stall_data_hazard;
   logic         Flush;
   logic [1:0]   Occupancy;
   logic [15:0]  Bubble_count;

   id_issue_queue #(.PAYLOAD_W(128), .TRACK_W(8), .DEPTH(DEPTH), .NOP_PAYLOAD('0), .CNT_W(16)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .In_valid(In_valid), .In_ready(In_ready), .In_payload(In_payload), .In_tracker(In_tracker),
      .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_payload(Out_payload), .Out_tracker(Out_tracker),
      .Stall_data_hazard(Stall_data_hazard), .Flush(Flush),
      .Occupancy(Occupancy), .Bubble_count(Bubble_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard of {tracker, payload} plus bubble reference count.
   logic [135:0] sb [$];
   int           bub_m    = 0;
   int           out_seen = 0;
   bit           mon_on   = 0;

   always @(negedge Clk) begin
      logic [135:0] e;
      if (!Reset_n) begin
         sb.delete();
         bub_m = 0;
      end else if (mon_on) begin
         chk("occ",      128'(Occupancy),    128'(sb.size()));
         chk("in_rdy",   128'(In_ready),     128'(sb.size() != DEPTH));
         chk("out_vld",  128'(Out_valid),    128'(sb.size() != 0 && !Stall_data_hazard && !Flush));
         chk("bubbles",  128'(Bubble_count), 128'(bub_m));
         if (!Out_valid) begin
            chk("nop_pay", Out_payload, 128'h0);
            chk("nop_trk", 128'(Out_tracker), 128'h0);
         end
         if (Flush) begin
            sb.delete();
         end else begin
            if (Stall_data_hazard && sb.size() != 0 && bub_m != 16'hFFFF) bub_m++;
            if (Out_valid && Out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out", 128'(Out_payload), 128'h0);
               end else begin
                  e = sb.pop_front();
                  chk("sb_pay", Out_payload, e[127:0]);
                  chk("sb_trk", 128'(Out_tracker), 128'(e[135:128]));
                  out_seen++;
               end
            end
            if (In_valid && In_ready) sb.push_back({In_tracker, In_payload});
         end
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic offer(input logic [127:0] p, input logic [7:0] t);
      In_valid   = 1'b1;
      In_payload = p;
      In_tracker = t;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int base;
      Reset_n = 1'b0; In_valid = 1'b0; In_payload = '0; In_tracker = '0;
      Out_ready = 1'b0; Stall_data_hazard = 1'b0; Flush = 1'b0;
      #1;
      chk("rst_out_vld", 128'(Out_valid), 128'h0);
      chk("rst_in_rdy",  128'(In_ready),  128'h1);
      chk("rst_occ",     128'(Occupancy), 128'h0);
      chk("rst_pay",     Out_payload,     128'h0);
      chk("rst_bub",     128'(Bubble_count), 128'h0);
      cyc(); cyc();
      Reset_n = 1'b1;
      mon_on  = 1'b1;

      // single bundle, 1-cycle latency
      Out_ready = 1'b1;
      offer(128'hA1, 8'h01);
      cyc();
      In_valid = 1'b0;
      chk("t1_vld", 128'(Out_valid), 128'h1);
      chk("t1_pay", Out_payload, 128'hA1);
      chk("t1_trk", 128'(Out_tracker), 128'h01);
      cyc();
      chk("t1_occ", 128'(Occupancy), 128'h0);

      // fill, hold third offer, drain in order
      Out_ready = 1'b0;
      offer(128'hB1, 8'h11); cyc();
      offer(128'hB2, 8'h12); cyc();
      chk("t2_occ", 128'(Occupancy), 128'h2);
      chk("t2_rdy", 128'(In_ready),  128'h0);
      offer(128'hB3, 8'h13); cyc();
      chk("t2_held", 128'(Occupancy), 128'h2);
      Out_ready = 1'b1;
      cyc(); cyc();
      In_valid = 1'b0;
      cyc(); cyc();
      chk("t2_drained", 128'(sb.size()), 128'h0);
      chk("t2_seen", 128'(out_seen), 128'h4);

      // stall 3 cycles on C1
      Out_ready = 1'b0;
      offer(128'hC1, 8'h21); cyc();
      In_valid = 1'b0;
      Out_ready = 1'b1;
      Stall_data_hazard = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_vld", 128'(Out_valid), 128'h0);
         chk("t3_nop", Out_payload, 128'h0);
         cyc();
      end
      Stall_data_hazard = 1'b0;
      #1;
      chk("t3_bub", 128'(Bubble_count), 128'h3);
      chk("t3_vld_after", 128'(Out_valid), 128'h1);
      chk("t3_pay", Out_payload, 128'hC1);
      cyc();

      // flush a full queue with an incoming bundle
      Out_ready = 1'b0;
      offer(128'hD1, 8'h31); cyc();
      offer(128'hD2, 8'h32); cyc();
      offer(128'hD3, 8'h33);
      Flush = 1'b1;
      #1;
      chk("t4_vld_in_flush", 128'(Out_valid), 128'h0);
      cyc();
      Flush = 1'b0;
      In_valid = 1'b0;
      #1;
      chk("t4_occ", 128'(Occupancy), 128'h0);
      chk("t4_vld", 128'(Out_valid), 128'h0);
      chk("t4_rdy", 128'(In_ready),  128'h1);
      Out_ready = 1'b1;
      base = out_seen;
      repeat (3) cyc();
      chk("t4_nothing_out", 128'(out_seen - base), 128'h0);

      // stream 10 bundles, Out_ready toggling
      sent = 0;
      base = out_seen;
      for (int k = 0; k < 100 && (out_seen - base) < 10; k++) begin
         Out_ready = (k % 2 == 0);
         In_valid  = (sent < 10);
         In_payload = 128'hE0 + 128'(sent);
         In_tracker = 8'(8'h40 + sent);
         if (In_valid && In_ready) sent++;
         cyc();
      end
      In_valid = 1'b0;
      chk("t5_sent", 128'(sent), 128'd10);
      chk("t5_seen", 128'(out_seen - base), 128'd10);
      chk("t5_empty", 128'(sb.size()), 128'h0);

      // async reset mid-stream with bubbles outstanding
      Out_ready = 1'b0;
      offer(128'hF1, 8'h51); cyc();
      In_valid = 1'b0;
      Stall_data_hazard = 1'b1;
      cyc(); cyc();
      Stall_data_hazard = 1'b0;
      offer(128'hF2, 8'h52);
      #1;
      chk("t6_pre_bub", 128'(Bubble_count), 128'h5);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("t6_vld", 128'(Out_valid), 128'h0);
      chk("t6_pay", Out_payload, 128'h0);
      chk("t6_trk", 128'(Out_tracker), 128'h0);
      chk("t6_rdy", 128'(In_ready), 128'h1);
      chk("t6_occ", 128'(Occupancy), 128'h0);
      chk("t6_bub", 128'(Bubble_count), 128'h0);
      In_valid = 1'b0;
      cyc();
      Reset_n = 1'b1;
      cyc();
      chk("t6_post_occ", 128'(Occupancy), 128'h0);
      Out_ready = 1'b1;
      offer(128'h99, 8'h77); cyc();
      In_valid = 1'b0;
      chk("t6_post_pay", Out_payload, 128'h99);
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
